// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } state_t;

    localparam logic [3:0] OP_HALT  = 4'hF;
    localparam logic [3:0] REG_ZERO = 4'h0;

    // Instruction field positions (each field is 4 bits wide).
    localparam int OP_LSB = 12;
    localparam int RS_LSB = 8;
    localparam int RT_LSB = 4;

    function automatic logic [3:0] opField(input logic [15:0] instruc);
        return instruc[OP_LSB +: 4];
    endfunction

    function automatic logic [3:0] rsField(input logic [15:0] instruc);
        return instruc[RS_LSB +: 4];
    endfunction

    function automatic logic [3:0] rtField(input logic [15:0] instruc);
        return instruc[RT_LSB +: 4];
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Signal bundle between the ID-stage observers and the pipeline control sequencer.
// There is no valid/ready handshake here: every input is a level that the
// controller samples on each rising clk edge, and every output is a per-cycle
// enable that the pipeline registers consume on that same edge.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic [15:0] ifIdInstruc;
    logic        idExMemRead;
    logic [3:0]  idExRt;
    logic        branchTaken;
    logic        memBusy;
    logic        resume;

    logic        pcWrite;
    logic        wrtIfId;
    logic        IFlush;
    logic        idExFlush;
    logic        halted;
    logic        memErr;
    logic [7:0]  stallCnt;
    state_t      dbgState;

    // Controller side.
    modport master (
        input  ifIdInstruc, idExMemRead, idExRt, branchTaken, memBusy, resume,
        output pcWrite, wrtIfId, IFlush, idExFlush, halted, memErr, stallCnt, dbgState
    );

    // Pipeline side.
    modport slave (
        output ifIdInstruc, idExMemRead, idExRt, branchTaken, memBusy, resume,
        input  pcWrite, wrtIfId, IFlush, idExFlush, halted, memErr, stallCnt, dbgState
    );

endinterface

// File: rtl/pipe_ctrl_hazard_cmp.sv
// Load-use comparator: the load in ID/EX writes a register the IF/ID instruction reads.
module hazard_cmp
    import pipe_ctrl_pkg::*;
(
    input  logic [15:0] ifIdInstruc,
    input  logic        idExMemRead,
    input  logic [3:0]  idExRt,
    output logic        hazard
);

    // Register zero is never a real dependency.
    always_comb begin
        hazard = idExMemRead && (idExRt != REG_ZERO) &&
                 ((idExRt == rsField(ifIdInstruc)) || (idExRt == rtField(ifIdInstruc)));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control sequencer: stalls, branch flushes, memory freezes and halt.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 16,
    parameter int BRANCH_SLOTS = 1
)(
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.master bus
);

    // FLUSH holds the slots after the branch cycle; MEM_WAIT counts busy cycles seen.
    localparam logic [2:0] LAST_SLOT = 3'(BRANCH_SLOTS - 1);
    localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

    state_t     state, nextState;
    logic [7:0] waitCnt, waitCntNext;
    logic [2:0] slotCnt, slotCntNext;
    logic       memErrQ, memErrNext;
    logic [7:0] stallCntQ;
    logic       hazard;

    logic pcWriteC, wrtIfIdC, iFlushC, idExFlushC, haltedC;

    hazard_cmp uHazard (
        .ifIdInstruc (bus.ifIdInstruc),
        .idExMemRead (bus.idExMemRead),
        .idExRt      (bus.idExRt),
        .hazard      (hazard)
    );

    // Next-state and Mealy output decode; everything forced low while in reset.
    always_comb begin
        nextState   = state;
        waitCntNext = waitCnt;
        slotCntNext = slotCnt;
        memErrNext  = memErrQ;
        pcWriteC    = 1'b0;
        wrtIfIdC    = 1'b0;
        iFlushC     = 1'b0;
        idExFlushC  = 1'b0;
        haltedC     = 1'b0;

        case (state)
            RUN: begin
                if (bus.memBusy) begin
                    nextState   = MEM_WAIT;
                    waitCntNext = 8'd0;
                end else if (hazard) begin
                    idExFlushC = 1'b1;
                end else if (bus.branchTaken) begin
                    pcWriteC = 1'b1;
                    iFlushC  = 1'b1;
                    if (BRANCH_SLOTS > 1) begin
                        nextState   = FLUSH;
                        slotCntNext = 3'd1;
                    end
                end else if (opField(bus.ifIdInstruc) == OP_HALT) begin
                    nextState = HALT;
                end else begin
                    pcWriteC = 1'b1;
                    wrtIfIdC = 1'b1;
                end
            end
            FLUSH: begin
                // A memory stall freezes the pipe and abandons the remaining slots.
                if (bus.memBusy) begin
                    nextState   = MEM_WAIT;
                    waitCntNext = 8'd0;
                end else begin
                    pcWriteC = 1'b1;
                    iFlushC  = 1'b1;
                    if (slotCnt == LAST_SLOT) begin
                        nextState = RUN;
                    end else begin
                        slotCntNext = slotCnt + 3'd1;
                    end
                end
            end
            MEM_WAIT: begin
                if (!bus.memBusy) begin
                    nextState = RUN;
                end else if (waitCnt == LAST_WAIT) begin
                    nextState  = HALT;
                    memErrNext = 1'b1;
                end else begin
                    waitCntNext = waitCnt + 8'd1;
                end
            end
            HALT: begin
                haltedC = 1'b1;
                if (bus.resume) begin
                    // The halt instruction in IF/ID is replaced by a nop.
                    pcWriteC   = 1'b1;
                    iFlushC    = 1'b1;
                    memErrNext = 1'b0;
                    nextState  = RUN;
                end
            end
            default: nextState = RUN;
        endcase

        if (rst) begin
            pcWriteC   = 1'b0;
            wrtIfIdC   = 1'b0;
            iFlushC    = 1'b0;
            idExFlushC = 1'b0;
            haltedC    = 1'b0;
        end
    end

    // State, counters, sticky error and saturating stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            waitCnt   <= 8'd0;
            slotCnt   <= 3'd0;
            memErrQ   <= 1'b0;
            stallCntQ <= 8'd0;
        end else begin
            state   <= nextState;
            waitCnt <= waitCntNext;
            slotCnt <= slotCntNext;
            memErrQ <= memErrNext;
            if (!wrtIfIdC && !iFlushC && (stallCntQ != 8'hFF)) begin
                stallCntQ <= stallCntQ + 8'd1;
            end
        end
    end

    assign bus.pcWrite   = pcWriteC;
    assign bus.wrtIfId   = wrtIfIdC;
    assign bus.IFlush    = iFlushC;
    assign bus.idExFlush = idExFlushC;
    assign bus.halted    = haltedC;
    assign bus.memErr    = memErrQ;
    assign bus.stallCnt  = stallCntQ;
    assign bus.dbgState  = state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl against a cycle-level behavioural model.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int MT = 4;
    localparam int BS = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_ctrl_if bus();

    pipe_ctrl #(.MEM_TIMEOUT(MT), .BRANCH_SLOTS(BS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard ----------------
    int nCmp = 0;
    int nBad = 0;
    logic [13:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        if (obs !== exp) begin
            nBad++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The pipe is in one of: halted, frozen on memory, draining branch slots, or running.
    bit mHalt, mWait, mErr;
    int mWaitBusy, mFlushLeft, mStall;

    task automatic model_reset();
        mHalt = 0; mWait = 0; mErr = 0;
        mWaitBusy = 0; mFlushLeft = 0; mStall = 0;
        exp_q.delete();
    endtask

    // Returns the expected output vector for this cycle and advances the model.
    task automatic model_cycle(input logic [15:0] ins, input bit mr, input logic [3:0] rt,
                               input bit br, input bit busy, input bit res,
                               output logic [13:0] e);
        bit pc, wr, fl, idf, hl, lu;
        logic [7:0] stallNow;
        pc = 0; wr = 0; fl = 0; idf = 0; hl = 0;
        stallNow = 8'(mStall);
        e = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mErr, stallNow};
        lu = mr && (rt != 4'd0) && (rt == ins[11:8] || rt == ins[7:4]);
        if (mHalt) begin
            hl = 1;
            if (res) begin pc = 1; fl = 1; mHalt = 0; mErr = 0; end
        end else if (mWait) begin
            if (!busy) mWait = 0;
            else begin
                mWaitBusy++;
                if (mWaitBusy == MT) begin mWait = 0; mHalt = 1; mErr = 1; end
            end
        end else if (mFlushLeft > 0) begin
            if (busy) begin mFlushLeft = 0; mWait = 1; mWaitBusy = 0; end
            else begin pc = 1; fl = 1; mFlushLeft--; end
        end else begin
            if (busy) begin mWait = 1; mWaitBusy = 0; end
            else if (lu) idf = 1;
            else if (br) begin pc = 1; fl = 1; mFlushLeft = BS - 1; end
            else if (ins[15:12] == 4'hF) mHalt = 1;
            else begin pc = 1; wr = 1; end
        end
        e[13:9] = {pc, wr, fl, idf, hl};
        if (!wr && !fl && mStall < 255) mStall++;
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic [15:0] ins, input bit mr, input logic [3:0] rt,
                        input bit br, input bit busy, input bit res);
        logic [13:0] e;
        logic [13:0] got;
        @(negedge clk);
        rst = 1'b0;
        bus.ifIdInstruc = ins; bus.idExMemRead = mr; bus.idExRt = rt;
        bus.branchTaken = br;  bus.memBusy = busy;  bus.resume = res;
        model_cycle(ins, mr, rt, br, busy, res, e);
        exp_q.push_back(e);
        #1;
        got = {bus.pcWrite, bus.wrtIfId, bus.IFlush, bus.idExFlush, bus.halted, bus.memErr, bus.stallCnt};
        e = exp_q.pop_front();
        check("pcWrite",   32'(got[13]),  32'(e[13]));
        check("wrtIfId",   32'(got[12]),  32'(e[12]));
        check("IFlush",    32'(got[11]),  32'(e[11]));
        check("idExFlush", 32'(got[10]),  32'(e[10]));
        check("halted",    32'(got[9]),   32'(e[9]));
        check("memErr",    32'(got[8]),   32'(e[8]));
        check("stallCnt",  32'(got[7:0]), 32'(e[7:0]));
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must drop at once.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check({tag, "_pcWrite"},   32'(bus.pcWrite),   0);
        check({tag, "_wrtIfId"},   32'(bus.wrtIfId),   0);
        check({tag, "_IFlush"},    32'(bus.IFlush),    0);
        check({tag, "_idExFlush"}, 32'(bus.idExFlush), 0);
        check({tag, "_halted"},    32'(bus.halted),    0);
        check({tag, "_memErr"},    32'(bus.memErr),    0);
        check({tag, "_stallCnt"},  32'(bus.stallCnt),  0);
        model_reset();
        @(posedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int busyLeft;
        logic [15:0] ins;
        logic [3:0]  rt;
        bit busy;
        bus.ifIdInstruc = 16'h0; bus.idExMemRead = 0; bus.idExRt = 4'h0;
        bus.branchTaken = 0; bus.memBusy = 0; bus.resume = 0;
        model_reset();

        do_reset("rst0");

        // Load-use: one stall cycle, then the load has moved on.
        step(16'h1345, 1, 4'd3, 0, 0, 0);
        step(16'h1345, 0, 4'd3, 0, 0, 0);
        check("lu_stallCnt", 32'(bus.stallCnt), 1);
        step(16'h1045, 1, 4'd0, 0, 0, 0);   // rt = r0 never stalls
        check("lu_r0_wrtIfId", 32'(bus.wrtIfId), 1);

        // Taken branch: two flush cycles, then normal fetch.
        step(16'h2000, 0, 4'd0, 1, 0, 0);
        step(16'h2000, 0, 4'd0, 0, 0, 0);
        check("br_slot2_IFlush", 32'(bus.IFlush), 1);
        step(16'h2000, 0, 4'd0, 0, 0, 0);
        check("br_done_wrtIfId", 32'(bus.wrtIfId), 1);

        // Memory busy 3 cycles with a pending load-use: 4 frozen cycles.
        do_reset("rst1");
        repeat (3) step(16'h1345, 1, 4'd3, 0, 1, 0);
        step(16'h1345, 1, 4'd3, 0, 0, 0);
        step(16'h1345, 1, 4'd3, 0, 0, 0);
        check("mw_stallCnt", 32'(bus.stallCnt), 4);
        check("mw_then_lu", 32'(bus.idExFlush), 1);

        // Timeout: busy held -> HALT with memErr, resume clears it.
        repeat (5) step(16'h3000, 0, 4'd0, 0, 1, 0);
        step(16'h3000, 0, 4'd0, 0, 1, 0);
        check("to_halted", 32'(bus.halted), 1);
        check("to_memErr", 32'(bus.memErr), 1);
        step(16'h3000, 0, 4'd0, 0, 0, 1);
        check("to_resume_IFlush", 32'(bus.IFlush), 1);
        step(16'h3000, 0, 4'd0, 0, 0, 0);
        check("to_memErr_clr", 32'(bus.memErr), 0);

        // Halt opcode.
        step(16'hF000, 0, 4'd0, 0, 0, 0);
        repeat (3) step(16'hF000, 0, 4'd0, 0, 0, 0);
        step(16'hF000, 0, 4'd0, 0, 0, 1);
        step(16'h4000, 0, 4'd0, 0, 0, 0);

        // Reset during FLUSH and during MEM_WAIT.
        step(16'h2000, 0, 4'd0, 1, 0, 0);
        do_reset("rst_flush");
        step(16'h4000, 0, 4'd0, 0, 0, 0);
        step(16'h4000, 0, 4'd0, 0, 1, 0);
        step(16'h4000, 0, 4'd0, 0, 1, 0);
        do_reset("rst_wait");
        step(16'h4000, 0, 4'd0, 0, 0, 0);

        // Saturation: 300+ halted cycles.
        step(16'hF000, 0, 4'd0, 0, 0, 0);
        repeat (300) step(16'hF000, 0, 4'd0, 0, 0, 0);
        check("sat_stallCnt", 32'(bus.stallCnt), 255);
        step(16'hF000, 0, 4'd0, 0, 0, 1);

        // Randomized traffic.
        busyLeft = 0;
        for (int i = 0; i < 3000; i++) begin
            if (busyLeft > 0) begin busy = 1; busyLeft--; end
            else if ($urandom_range(0, 9) == 0) begin busy = 1; busyLeft = $urandom_range(0, 6); end
            else busy = 0;
            ins = 16'($urandom);
            rt = ($urandom_range(0, 1) == 1) ? ins[11:8] : 4'($urandom_range(0, 15));
            step(ins, 1'($urandom_range(0, 1)), rt, $urandom_range(0, 4) == 0, busy,
                 $urandom_range(0, 3) == 0);
            if (i == 1500) do_reset("rst_rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
